// File: rtl/rf_sched_pkg.sv
// -----------------------------------------------------------------------------
// rf_sched_pkg
// Shared definitions for the register-file write scheduler:
//   - sched_state_e : scheduler state encoding (ST_INIT, ST_RUN)
//   - clog2         : elaboration-time ceiling log2 used to size index fields
//   - DEF_*         : default widths used by the scheduler and its users
// Optional feature macro used by the scheduler: RF_WRITE_SCHED_INIT_EN.
// -----------------------------------------------------------------------------
package rf_sched_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 4;

    // Ceiling log2; returns at least 1 so a 2-requester index is still 1 bit wide.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rf_write_scheduler_arbiter.sv
// -----------------------------------------------------------------------------
// rf_rr_arbiter
// Purely combinational round-robin picker. Scans the request vector starting
// at ptr+1 (mod NUM_REQ) and returns the first asserted requester. The
// pointer register itself lives in the parent so it only advances on an
// actual transfer.
// Ports:
//   req     in  NUM_REQ  request vector
//   ptr     in  IDX_W    index of the most recent winner
//   gnt     out NUM_REQ  one-hot grant (zero when no request)
//   gnt_idx out IDX_W    binary index of the granted requester
//   gnt_any out 1        some requester was granted
// -----------------------------------------------------------------------------
module rf_rr_arbiter
    import rf_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = clog2(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_any
);

    logic [IDX_W-1:0] cand_s;

    // Rotating priority scan: offset 1 first, offset NUM_REQ (the last winner) last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand_s  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!gnt_any && req[cand_s]) begin
                gnt[cand_s] = 1'b1;
                gnt_idx     = cand_s;
                gnt_any     = 1'b1;
            end else begin
                gnt_any = gnt_any;
            end
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// -----------------------------------------------------------------------------
// rf_write_scheduler
// Shares the single write port of a LUT-RAM register file among NUM_REQ
// requesters using round-robin valid/ready arbitration. The accepted request
// is registered and driven onto WE/ADDR_IN/D_IN one cycle after the transfer;
// those registered signals double as the bypass view of the in-flight write.
//
// Optional feature (macro RF_WRITE_SCHED_INIT_EN): after reset an INIT state
// sweeps every entry 0..DEPTH-1 with INIT_VALUE before requests are accepted.
// The DEPTH and INIT_VALUE parameters exist only when the macro is defined.
// Without it the scheduler comes out of reset directly in RUN.
//
// Ports:
//   CLK        in  1                   clock
//   rst_n      in  1                   asynchronous active-low reset
//   req_valid  in  NUM_REQ             per-requester write request
//   req_ready  out NUM_REQ             per-requester accept (one-hot or zero)
//   req_addr   in  NUM_REQ*ADDR_WIDTH  request i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data   in  NUM_REQ*DATA_WIDTH  request i at [i*DATA_WIDTH +: DATA_WIDTH]
//   hold       in  1                   no new grants while high
//   WE         out 1                   register file write enable
//   ADDR_IN    out ADDR_WIDTH          register file write address
//   D_IN       out DATA_WIDTH          register file write data
//   grant_id   out clog2(NUM_REQ)      requester owning the current WE cycle
//   init_done  out 1                   high once requests are being accepted
// -----------------------------------------------------------------------------
module rf_write_scheduler
    import rf_sched_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
`ifdef RF_WRITE_SCHED_INIT_EN
    ,
    parameter int                    DEPTH      = 1 << ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = {DATA_WIDTH{1'b0}}
`endif
) (
    input  logic                          CLK,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          hold,
    output logic                          WE,
    output logic [ADDR_WIDTH-1:0]         ADDR_IN,
    output logic [DATA_WIDTH-1:0]         D_IN,
    output logic [clog2(NUM_REQ)-1:0]     grant_id,
    output logic                          init_done
);

    localparam int IDX_W = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    gnt_s;
    logic [IDX_W-1:0]      gnt_idx_s;
    logic                  gnt_any_s;
    logic                  run_s;
    logic                  xfer_s;
    logic [NUM_REQ-1:0]    ready_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_data_s;

    logic [IDX_W-1:0]      ptr_r;
    logic                  we_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data_r;
    logic [IDX_W-1:0]      gid_r;
    logic                  init_done_r;

    rf_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .gnt_any (gnt_any_s)
    );

`ifdef RF_WRITE_SCHED_INIT_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    sched_state_e          state_r;
    logic [ADDR_WIDTH-1:0] sweep_r;

    // INIT sweep counter; leaves INIT on the cycle that issues the last entry.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
            sweep_r <= '0;
        end else if (state_r == ST_INIT) begin
            sweep_r <= sweep_r + ADDR_WIDTH'(1);
            if (sweep_r == LAST_ADDR) begin
                state_r <= ST_RUN;
            end else begin
                state_r <= ST_INIT;
            end
        end else begin
            state_r <= ST_RUN;
            sweep_r <= sweep_r;
        end
    end

    assign run_s = (state_r == ST_RUN);
`else
    assign run_s = 1'b1;
`endif

    // Ready is combinational on valid so a request can transfer in the cycle it appears.
    always_comb begin
        if (run_s && !hold) begin
            ready_s = gnt_s;
        end else begin
            ready_s = '0;
        end
    end

    assign req_ready = ready_s;
    // A grant always implies the corresponding valid, so this is valid & ready.
    assign xfer_s    = gnt_any_s & run_s & ~hold;

    // One-hot grant selects the winner's address and data slice.
    always_comb begin
        sel_addr_s = '0;
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_s[i]) begin
                sel_addr_s = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data_s = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                sel_addr_s = sel_addr_s;
            end
        end
    end

    // Write-port pipeline register and round-robin pointer; pointer moves only on a transfer.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            we_r   <= 1'b0;
            addr_r <= '0;
            data_r <= '0;
            gid_r  <= '0;
            ptr_r  <= IDX_W'(NUM_REQ - 1);
        end else begin
`ifdef RF_WRITE_SCHED_INIT_EN
            if (!run_s) begin
                we_r   <= 1'b1;
                addr_r <= sweep_r;
                data_r <= INIT_VALUE;
                gid_r  <= '0;
            end else
`endif
            if (xfer_s) begin
                we_r   <= 1'b1;
                addr_r <= sel_addr_s;
                data_r <= sel_data_s;
                gid_r  <= gnt_idx_s;
                ptr_r  <= gnt_idx_s;
            end else begin
                // ADDR_IN/D_IN hold their last value; only the enable drops.
                we_r   <= 1'b0;
            end
        end
    end

    // init_done is a registered copy of "in RUN".
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            init_done_r <= 1'b0;
        end else begin
            init_done_r <= run_s;
        end
    end

    assign WE        = we_r;
    assign ADDR_IN   = addr_r;
    assign D_IN      = data_r;
    assign grant_id  = gid_r;
    assign init_done = init_done_r;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// -----------------------------------------------------------------------------
// tb_rf_write_scheduler
// Directed stimulus with hand-computed expected writes pushed into a queue;
// an independent monitor pops and compares every WE cycle. A small register
// file model captures writes so read-after-write timing can be checked.
// Builds with or without RF_WRITE_SCHED_INIT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rf_write_scheduler;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam logic [DW-1:0] INIT_VAL = 32'h0000_00A5;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [1:0]    gid;
    } exp_t;

    logic              CLK = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_data;
    logic              hold;
    logic              WE;
    logic [AW-1:0]     ADDR_IN;
    logic [DW-1:0]     D_IN;
    logic [1:0]        grant_id;
    logic              init_done;

    exp_t          exp_q[$];
    logic [DW-1:0] mem [0:(1<<AW)-1];
    int            checks = 0;
    int            errors = 0;

    rf_write_scheduler #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
`ifdef RF_WRITE_SCHED_INIT_EN
        ,
        .DEPTH      (1 << AW),
        .INIT_VALUE (INIT_VAL)
`endif
    ) dut (
        .CLK       (CLK),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .hold      (hold),
        .WE        (WE),
        .ADDR_IN   (ADDR_IN),
        .D_IN      (D_IN),
        .grant_id  (grant_id),
        .init_done (init_done)
    );

    always #5 CLK = ~CLK;

    // Register file model: write lands at the edge ending the WE cycle.
    always @(posedge CLK) begin
        if (WE === 1'b1) begin
            mem[ADDR_IN] <= D_IN;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] g);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.gid  = g;
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic push_sweep();
        logic [AW-1:0] a;
        for (int i = 0; i < (1 << AW); i++) begin
            a = AW'(i);
            push(a, INIT_VAL, 2'd0);
        end
    endtask

    // Monitor: every write on the port must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (rst_n === 1'b1 && WE === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=addr %0h data %0h gid %0d required=no write",
                             ADDR_IN, D_IN, grant_id);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(ADDR_IN), 64'(e.addr));
                    chk("wr_data", 64'(D_IN), 64'(e.data));
                    chk("wr_gid", 64'(grant_id), 64'(e.gid));
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        hold      = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;

        // Reset values
        #3;
        chk("rst_we", 64'(WE), 64'd0);
        chk("rst_addr", 64'(ADDR_IN), 64'd0);
        chk("rst_data", 64'(D_IN), 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
`ifdef RF_WRITE_SCHED_INIT_EN
        push_sweep();
`endif
        @(negedge CLK);
        @(negedge CLK);
        rst_n = 1'b1;
`ifdef RF_WRITE_SCHED_INIT_EN
        // Sweep: 16 writes, init_done at the 17th edge
        repeat (16) @(negedge CLK);
        chk("init_done_c16", 64'(init_done), 64'd0);
        @(negedge CLK);
        chk("init_done_c17", 64'(init_done), 64'd1);
        for (int i = 0; i < (1 << AW); i++) begin
            chk("sweep_mem", 64'(mem[i]), 64'(INIT_VAL));
        end
`else
        @(negedge CLK);
        chk("init_done_first_clk", 64'(init_done), 64'd1);
`endif

        // All four valid: strict rotation 0,1,2,3,0,1,2,3
        for (int i = 0; i < NR; i++) begin
            set_req(i, 1'b1, AW'(8 + i), 32'h100 + i);
        end
        for (int k = 0; k < 8; k++) begin
            push(AW'(8 + (k % 4)), 32'h100 + (k % 4), 2'(k % 4));
        end
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
            @(negedge CLK);
        end
        req_valid = '0;
        @(negedge CLK);

        // Single write latency: transfer at t, WE at t+1, readable at t+2
        set_req(2, 1'b1, 4'd5, 32'h0000_1234);
        push(4'd5, 32'h0000_1234, 2'd2);
        #1;
        chk("single_ready", 64'(req_ready), 64'(4'b0100));
        @(posedge CLK);
        #1;
        chk("lat_we_t1", 64'(WE), 64'd1);
        chk("lat_addr_t1", 64'(ADDR_IN), 64'd5);
        @(negedge CLK);
        req_valid = '0;
        @(posedge CLK);
        #1;
        chk("lat_mem_t2", 64'(mem[5]), 64'h1234);
        chk("lat_we_t2", 64'(WE), 64'd0);
        chk("hold_addr_t2", 64'(ADDR_IN), 64'd5);
        @(negedge CLK);

        // Move pointer to 0, then same-address collision 1 vs 3
        set_req(0, 1'b1, 4'd0, 32'h0000_00AA);
        push(4'd0, 32'h0000_00AA, 2'd0);
        @(negedge CLK);
        req_valid = '0;
        set_req(1, 1'b1, 4'd7, 32'h0000_0011);
        set_req(3, 1'b1, 4'd7, 32'h0000_0033);
        push(4'd7, 32'h0000_0011, 2'd1);
        push(4'd7, 32'h0000_0033, 2'd3);
        #1;
        chk("collide_ready1", 64'(req_ready), 64'(4'b0010));
        @(negedge CLK);
        req_valid[1] = 1'b0;
        #1;
        chk("collide_ready3", 64'(req_ready), 64'(4'b1000));
        @(negedge CLK);
        req_valid[3] = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("collide_mem7", 64'(mem[7]), 64'h33);

        // hold for 5 cycles with all valid; resume from unchanged pointer
        for (int i = 0; i < NR; i++) begin
            set_req(i, 1'b1, AW'(8 + i), 32'h200 + i);
        end
        push(4'd8, 32'h200, 2'd0);
        #1;
        chk("pre_hold_ready", 64'(req_ready), 64'(4'b0001));
        @(negedge CLK);
        hold = 1'b1;
        #1;
        chk("hold_ready", 64'(req_ready), 64'd0);
        chk("hold_inflight_we", 64'(WE), 64'd1);
        @(negedge CLK);
        chk("hold_we_drop", 64'(WE), 64'd0);
        repeat (4) begin
            @(negedge CLK);
            chk("hold_ready_cont", 64'(req_ready), 64'd0);
        end
        hold = 1'b0;
        push(4'd9, 32'h201, 2'd1);
        push(4'd10, 32'h202, 2'd2);
        #1;
        chk("resume_ready1", 64'(req_ready), 64'(4'b0010));
        @(negedge CLK);
        #1;
        chk("resume_ready2", 64'(req_ready), 64'(4'b0100));
        @(negedge CLK);
        req_valid = '0;
        @(negedge CLK);

        // Reset while WE is high: WE drops with no clock edge
        set_req(0, 1'b1, 4'd3, 32'h0000_5555);
        push(4'd3, 32'h0000_5555, 2'd0);
        @(negedge CLK);
        req_valid = '0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", 64'(WE), 64'd0);
        chk("async_rst_addr", 64'(ADDR_IN), 64'd0);
        chk("async_rst_data", 64'(D_IN), 64'd0);
        chk("async_rst_init_done", 64'(init_done), 64'd0);
`ifdef RF_WRITE_SCHED_INIT_EN
        push_sweep();
`endif
        @(negedge CLK);
        rst_n = 1'b1;
`ifdef RF_WRITE_SCHED_INIT_EN
        repeat (17) @(negedge CLK);
`else
        @(negedge CLK);
`endif
        chk("rerun_init_done", 64'(init_done), 64'd1);

        // After reset requester 0 wins first again
        set_req(3, 1'b1, 4'd1, 32'h0000_0303);
        set_req(0, 1'b1, 4'd2, 32'h0000_0404);
        push(4'd2, 32'h0000_0404, 2'd0);
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'(4'b0001));
        @(negedge CLK);
        req_valid = '0;

        // Bounded drain of the scoreboard
        repeat (4) @(negedge CLK);
        chk("queue_drain", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
